// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter with a valid/ready load
// handshake. A DATA_WIDTH word is emitted one bit per enabled clock, either
// MSB-first (dir=0) or LSB-first (dir=1). A new word may be loaded on the same
// edge that consumes the last bit of the current frame, so frames can run
// back to back without an idle gap.
module piso_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] p_in,
    input  logic                  dir,
    input  logic                  shift_en,
    output logic                  s_out,
    output logic                  s_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  last_bit;

    // The counter holds the number of bits still to come after the one on
    // s_out, so counter==0 with shift_en marks the last-bit edge, where a
    // fresh word may already be taken.
    assign last_bit   = (state_q == SHIFT) && shift_en && (cnt_q == '0);
    assign load_ready = (state_q == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    assign busy    = (state_q == SHIFT);
    assign s_valid = (state_q == SHIFT) && shift_en;
    assign s_out   = (state_q == SHIFT) ? (dir_q ? sreg_q[0] : sreg_q[DATA_WIDTH-1]) : 1'b0;
    assign done    = done_q;

    // Next-state logic: consume a bit when enabled, then let a handshake
    // override with a fresh load so a back-to-back word wins over the return to IDLE.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        if ((state_q == SHIFT) && shift_en) begin
            sreg_d = dir_q ? (sreg_q >> 1) : (sreg_q << 1);
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end

        if (accept) begin
            sreg_d  = p_in;
            dir_d   = dir;
            cnt_d   = CNT_W'(DATA_WIDTH - 1);
            state_d = SHIFT;
        end
    end

    // State registers; reset abandons any frame at once with no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer. A queue-based model
// of the frame in flight predicts every output on every cycle; a receive-side
// shift register rebuilds the word from s_out/s_valid like a loopback into
// shift_reg, and literal expectations pin the bit orders.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] p_in;
    logic         dir;
    logic         shift_en;
    logic         s_out;
    logic         s_valid;
    logic         busy;
    logic         done;

    int total_checks;
    int bad_checks;
    bit check_en;

    // Model: bits of the current frame still to be transmitted, in send order.
    bit           model_q[$];
    bit           model_done;
    logic [W-1:0] model_shift;
    logic [W-1:0] model_frame;

    // Receive side: loopback deserializer plus raw stream of transmitted bits.
    logic         rx_dir;
    logic [W-1:0] rx_word;
    logic [W-1:0] dut_stream;

    piso_serializer #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .p_in      (p_in),
        .dir       (dir),
        .shift_en  (shift_en),
        .s_out     (s_out),
        .s_valid   (s_valid),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total_checks++;
        if (actual !== required) begin
            bad_checks++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Drive inputs just after an edge, then advance one full clock.
    task automatic applyStimulus(input logic lv, input logic [W-1:0] p, input logic d, input logic se);
        load_valid = lv;
        p_in       = p;
        dir        = d;
        shift_en   = se;
        @(posedge clk);
        #1;
    endtask

    // Model update: a bit leaves on every enabled cycle of a frame, the frame
    // ends when its last bit leaves, and a word may be taken when idle or on
    // that last-bit edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
            model_done  = 1'b0;
            model_shift = '0;
        end else begin
            bit m_busy, m_last, m_ready;
            m_busy  = (model_q.size() > 0);
            m_last  = m_busy && shift_en && (model_q.size() == 1);
            m_ready = !m_busy || m_last;
            if (m_busy && shift_en) begin
                model_shift = {model_shift[W-2:0], model_q[0]};
                void'(model_q.pop_front());
                if (model_q.size() == 0) model_frame = model_shift;
            end
            if (load_valid && m_ready) begin
                for (int i = 0; i < W; i++) begin
                    model_q.push_back(dir ? p_in[i] : p_in[W-1-i]);
                end
            end
            model_done = m_last;
        end
    end

    // Receive side: capture each consumed bit the way shift_reg would.
    always @(posedge clk) begin
        if (s_valid === 1'b1) begin
            rx_word    <= rx_dir ? {s_out, rx_word[W-1:1]} : {rx_word[W-2:0], s_out};
            dut_stream <= {dut_stream[W-2:0], s_out};
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            bit e_busy;
            e_busy = (model_q.size() > 0);
            checkOutput("busy", busy, e_busy);
            checkOutput("s_valid", s_valid, e_busy && shift_en);
            checkOutput("s_out", s_out, e_busy ? model_q[0] : 1'b0);
            checkOutput("load_ready", load_ready, !e_busy || (shift_en && model_q.size() == 1));
            checkOutput("done", done, model_done);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        check_en     = 1'b0;
        load_valid   = 1'b0;
        p_in         = '0;
        dir          = 1'b0;
        shift_en     = 1'b0;
        rx_dir       = 1'b0;
        rx_word      = '0;
        dut_stream   = '0;
        model_frame  = '0;
        rst          = 1'b1;
        #2;
        check_en = 1'b1;

        // Reset held with random inputs: outputs stay idle.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        checkOutput("rst_ready", load_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // MSB first, continuous enable.
        rx_dir = 1'b0;
        applyStimulus(1'b1, 8'hA6, 1'b0, 1'b1);
        checkOutput("msb_first_bit", s_out, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("msb_done", done, 1'b1);
        checkOutput("msb_busy", busy, 1'b0);
        checkOutput("msb_stream", dut_stream, 8'hA6);
        checkOutput("msb_model", model_frame, 8'hA6);
        checkOutput("msb_loop", rx_word, 8'hA6);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("msb_done_end", done, 1'b0);

        // LSB first with stalls; dir toggled mid-frame must not matter.
        rx_dir = 1'b1;
        applyStimulus(1'b1, 8'hA6, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("lsb_third", s_out, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'(i), 1'b0);
        checkOutput("lsb_held", s_out, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("lsb_done", done, 1'b1);
        checkOutput("lsb_stream", dut_stream, 8'h65);
        checkOutput("lsb_model", model_frame, 8'h65);
        checkOutput("lsb_loop", rx_word, 8'hA6);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // Back-to-back frames with an ignored mid-frame offer.
        rx_dir = 1'b0;
        applyStimulus(1'b1, 8'hA6, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i == 3, 8'h55, 1'b1, 1'b1);
        end
        load_valid = 1'b1;
        p_in       = 8'h3C;
        dir        = 1'b0;
        #1;
        checkOutput("b2b_ready", load_ready, 1'b1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        #1;
        checkOutput("b2b_done", done, 1'b1);
        checkOutput("b2b_busy", busy, 1'b1);
        checkOutput("b2b_first", s_out, 1'b0);
        checkOutput("b2b_loop", rx_word, 8'hA6);
        for (int i = 0; i < W; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("b2b2_done", done, 1'b1);
        checkOutput("b2b2_busy", busy, 1'b0);
        checkOutput("b2b2_stream", dut_stream, 8'h3C);
        checkOutput("b2b2_model", model_frame, 8'h3C);

        // Reset mid-frame after four bits, then a clean frame of ones.
        applyStimulus(1'b1, 8'hA6, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_valid", s_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_done", done, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ff_done", done, 1'b1);
        checkOutput("ff_stream", dut_stream, 8'hFF);
        checkOutput("ff_loop", rx_word, 8'hFF);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
